// File: rtl/mask_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mask_rr_arbiter
//
// Registered one-hot mask arbiter. Arbitrates CH_NUM valid/ready request
// channels, holds a one-hot grant for a whole packet (until a beat with
// last), applies the grant as an AND-mask over the packed channel data and
// presents the selected beat on a single registered output port.
// Priority is round-robin (i_mode=0) or fixed, ch0 highest (i_mode=1).
//
// Parameters
//   DATA_WIDTH  width of one channel's data beat
//   CH_NUM      number of request channels (>= 2)
//   PTR_W       round-robin pointer width, derived from CH_NUM
//
// Ports
//   i_clk         clock, all logic on rising edge
//   i_rst         asynchronous, active-high reset
//   i_mode        0 = round-robin, 1 = fixed priority (sampled in IDLE only)
//   i_req_valid   per-channel beat valid
//   i_req_last    per-channel last beat of packet
//   i_req_data    packed beats, channel i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//   o_req_ready   per-channel beat accepted when valid & ready
//   o_out_valid   output beat valid
//   o_out_data    output beat
//   o_out_last    output beat is last of packet
//   o_out_grant   one-hot source channel of output beat
//   i_out_ready   downstream accepts output beat
// ---------------------------------------------------------------------------
module mask_rr_arbiter #(
    parameter  int DATA_WIDTH = 64,
    parameter  int CH_NUM     = 4,
    localparam int PTR_W      = $clog2(CH_NUM)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_mode,
    input  logic [CH_NUM-1:0]            i_req_valid,
    input  logic [CH_NUM-1:0]            i_req_last,
    input  logic [DATA_WIDTH*CH_NUM-1:0] i_req_data,
    output logic [CH_NUM-1:0]            o_req_ready,
    output logic                         o_out_valid,
    output logic [DATA_WIDTH-1:0]        o_out_data,
    output logic                         o_out_last,
    output logic [CH_NUM-1:0]            o_out_grant,
    input  logic                         i_out_ready
);

    localparam logic [PTR_W:0]   CH_NUM_EXT = (PTR_W+1)'(CH_NUM);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(CH_NUM - 1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [CH_NUM-1:0]       r_grant;
    logic [PTR_W-1:0]        r_ptr;
    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_out_last;
    logic [CH_NUM-1:0]       r_out_grant;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t                  w_state_nxt;
    logic [CH_NUM-1:0]       w_grant_nxt;
    logic [PTR_W-1:0]        w_ptr_nxt;

    logic                    w_out_free;
    logic [CH_NUM-1:0]       w_req_ready;
    logic                    w_xfer;
    logic                    w_beat_last;
    logic [DATA_WIDTH-1:0]   w_mask_data;
    logic [PTR_W-1:0]        w_grant_idx;

    logic [CH_NUM-1:0]       w_fix_win;
    logic                    w_fix_found;

    logic [CH_NUM-1:0]       w_rot;
    logic [PTR_W-1:0]        w_rr_off;
    logic                    w_rr_found;
    logic [PTR_W:0]          w_rr_sum;
    logic [CH_NUM-1:0]       w_rr_win;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // The output register can take a new beat when it is empty or being
    // drained this cycle; only the granted channel ever sees ready.
    assign w_out_free  = ~r_out_valid | i_out_ready;
    assign w_req_ready = ((r_state == ST_BUSY) && w_out_free) ? r_grant : '0;
    assign w_xfer      = |(w_req_ready & i_req_valid);
    assign w_beat_last = |(r_grant & i_req_last);
    assign o_req_ready = w_req_ready;

    // ------------------------------------------------------------------
    // Data mask: OR of every slice ANDed with its grant bit
    // ------------------------------------------------------------------
    always_comb begin
        w_mask_data = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            w_mask_data = w_mask_data |
                          (i_req_data[i*DATA_WIDTH +: DATA_WIDTH] &
                           {DATA_WIDTH{r_grant[i]}});
        end
    end

    // Binary index of the current grant, used to advance the pointer
    always_comb begin
        w_grant_idx = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (r_grant[i]) begin
                w_grant_idx = PTR_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Fixed priority: lowest-index valid channel
    // ------------------------------------------------------------------
    always_comb begin
        w_fix_win   = '0;
        w_fix_found = 1'b0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (i_req_valid[i] && !w_fix_found) begin
                w_fix_win[i] = 1'b1;
                w_fix_found  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin: rotate the request vector so bit 0 is channel r_ptr,
    // find the first set bit, then map the offset back to a channel index
    // modulo CH_NUM.
    // ------------------------------------------------------------------
    assign w_rot = CH_NUM'({i_req_valid, i_req_valid} >> r_ptr);

    always_comb begin
        w_rr_off   = '0;
        w_rr_found = 1'b0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (w_rot[i] && !w_rr_found) begin
                w_rr_off   = PTR_W'(i);
                w_rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_rr_sum = {1'b0, r_ptr} + {1'b0, w_rr_off};
        if (w_rr_sum >= CH_NUM_EXT) begin
            w_rr_sum = w_rr_sum - CH_NUM_EXT;
        end
    end

    always_comb begin
        w_rr_win = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            w_rr_win[i] = w_rr_found && (w_rr_sum == (PTR_W+1)'(i));
        end
    end

    // ------------------------------------------------------------------
    // FSM: state / grant / pointer
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = '0;
                if (|i_req_valid) begin
                    w_grant_nxt = i_mode ? w_fix_win : w_rr_win;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Grant is held until the last beat is accepted; a stalled
                // granted channel keeps every other channel blocked.
                if (w_xfer && w_beat_last) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = (w_grant_idx == PTR_LAST) ? '0
                                                            : w_grant_idx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_grant <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mask_data;
            r_out_last  <= w_beat_last;
            r_out_grant <= r_grant;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;
    assign o_out_grant = r_out_grant;

endmodule

// File: doc/mask_rr_arbiter.md
# mask_rr_arbiter

Parametrised, registered successor to the combinational one-hot data mask used by the read and write arbiters. It arbitrates CH_NUM valid/ready request channels, holds a one-hot grant for a whole packet (until a beat with last), applies that grant as an AND-mask over the packed channel data, and presents the selected beat on a single registered output port. Priority is selectable between round-robin and fixed. It sits between the per-port request logic and the memory-pool bank interface.

## Interface
- DATA_WIDTH, 64, width of one channel's data beat
- CH_NUM, 4, number of request channels (≥2)
- PTR_W, $clog2(CH_NUM), width of round-robin pointer (derived, not overridden)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  1  0 = round-robin, 1 = fixed priority (ch0 highest)
- req_valid  in  CH_NUM  per-channel beat valid
- req_last  in  CH_NUM  per-channel last beat of packet
- req_data  in  DATA_WIDTH*CH_NUM  packed beats, channel i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- req_ready  out  CH_NUM  per-channel beat accepted when valid & ready
- out_valid  out  1  output beat valid
- out_data  out  DATA_WIDTH  output beat
- out_last  out  1  output beat is last of packet
- out_grant  out  CH_NUM  one-hot source channel of output beat
- out_ready  in  1  downstream accepts output beat

## Operation
- States: IDLE, BUSY. Registers: state, grant (one-hot), ptr, out_valid, out_data, out_last, out_grant.
- IDLE: if any req_valid, select winner, register grant, go BUSY. No req_ready asserted in IDLE. No request: stay IDLE, grant = 0.
- Winner, mode=1: lowest-index valid channel. mode=0: first valid channel searching ptr, ptr+1, … wrapping CH_NUM-1 → 0. mode sampled only in IDLE.
- BUSY: req_ready = grant & {CH_NUM{~out_valid | out_ready}}; all non-granted bits 0.
- Beat transfer on granted channel g: out_data <= OR-reduction of (req_data slice i AND {DATA_WIDTH{grant[i]}}) over i, i.e. slice g; out_last <= req_last[g]; out_grant <= grant; out_valid <= 1.
- Transfer with req_last[g]=1: state <= IDLE, grant <= 0, ptr <= g+1, wrapping at CH_NUM to 0. ptr updates in both modes.
- Granted channel deasserting req_valid mid-packet: grant held, no transfer, no timeout. Other channels stay blocked.
- Output register: out_valid cleared when out_ready=1 and no new transfer that cycle. out_data/out_last/out_grant stable while out_valid=1 and out_ready=0.
- req_valid or req_last on non-granted channels ignored.

## Timing
- Reset, asynchronous: state=IDLE, grant=0, ptr=0, out_valid=0, out_data=0, out_last=0, out_grant=0. req_ready=0 since it is combinational from state/grant. Reset mid-packet discards the in-flight beat and grant.
- Arbitration: 1 cycle. Request seen in IDLE at edge N, grant registered at N, req_ready high during cycle N+1.
- Data latency: beat accepted at edge M appears on out_* after edge M, i.e. 1 cycle.
- Throughput in BUSY: 1 beat/cycle while out_ready=1. Per-packet overhead: 1 IDLE bubble cycle.
- Simultaneous out_ready=1 and new transfer: output register reloads and out_valid stays 1.
- Last-beat transfer and new requests in the same cycle: the new arbitration happens in the following IDLE cycle using the updated ptr.

## Test plan
- Reset mid-packet: ch1 granted, beat pending with out_ready=0, assert rst -> all outputs 0 immediately, state IDLE, ptr=0, next arbitration starts from ch0.
- Round-robin fairness: mode=0, all 4 channels valid with single-beat packets (last=1), data = 0xA0+i, out_ready=1 -> out_grant sequence 0001, 0010, 0100, 1000, 0001. out_data 0xA0..0xA3 repeating, one beat every 2 cycles.
- Fixed priority: mode=1, ch0 and ch3 continuously valid with 1-beat packets -> only ch0 served. Drop ch0 -> ch3 granted on next IDLE.
- Packet hold: ch2 sends 3-beat packet (last on beat 3) while ch0 valid; ch2 drops valid for 2 cycles mid-packet -> ch0 req_ready stays 0, ch2 beats appear in order with out_last only on beat 3, then ch0 granted.
- Backpressure: hold out_ready=0 for 3 cycles during a 4-beat ch1 packet -> out_data stable, req_ready[1]=0 while out_valid=1. No beat lost or duplicated; 4 beats out.
- Wrap: CH_NUM=3, DATA_WIDTH=8, mode=0, last grant ch2 -> ptr wraps to 0. With ch0 and ch1 valid, ch0 wins.
